// File: rtl/piece_move_scheduler.sv
// piece_move_scheduler
//   Funnels player moves (left/right/rotate/soft-drop) and the gravity tick
//   onto the update engine's single move port. Only one move is in flight at
//   a time. Detects landing (blocked down move) and emits a one-cycle lock.
//
// Parameters
//   GRAVITY_PERIOD : clk cycles between gravity ticks (>= 2)
//   CNT_W          : gravity counter width, must hold GRAVITY_PERIOD-1
//
// Ports
//   clk, iReset        : clock, synchronous active-high reset
//   iEn                : global enable, low freezes every register
//   iActive            : a piece is live; low drops all queued requests
//   iMoveLeft/Right/iRotate/iMoveDown : single-cycle request pulses
//   iMoveDone          : engine finished the in-flight move
//   iMoveBlocked       : with iMoveDone, the move was rejected
//   oMoveReq/oMoveCode : move strobe and code (00 L, 01 R, 10 down, 11 rot)
//   oLock              : one-cycle landing pulse
//   oBusy              : FSM not idle or a request is queued
//
// Build option
//   PIECE_MOVE_LOCK_DELAY_EN : the first blocked down only marks the piece
//   as landed; a second blocked down (with no successful down between)
//   produces the lock.
module piece_move_scheduler #(
   parameter int GRAVITY_PERIOD = 50000000,
   parameter int CNT_W          = 26
) (
   input  logic       clk,
   input  logic       iReset,
   input  logic       iEn,
   input  logic       iActive,
   input  logic       iMoveLeft,
   input  logic       iMoveRight,
   input  logic       iRotate,
   input  logic       iMoveDown,
   input  logic       iMoveDone,
   input  logic       iMoveBlocked,
   output logic       oMoveReq,
   output logic [1:0] oMoveCode,
   output logic       oLock,
   output logic       oBusy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_LOCK  = 2'b11
   } state_t;

   localparam logic [1:0] CODE_LEFT  = 2'b00;
   localparam logic [1:0] CODE_RIGHT = 2'b01;
   localparam logic [1:0] CODE_DOWN  = 2'b10;
   localparam logic [1:0] CODE_ROT   = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GRAVITY_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   state_t           state_q;
   logic [3:0]       pend_q, pend_d;   // bit index equals the move code
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       code_q;
   logic             req_q;
   logic             lock_q;
`ifdef PIECE_MOVE_LOCK_DELAY_EN
   logic             landed_q;
`endif

   logic             tick_s;
   logic             grant_s;
   logic [1:0]       win_code_s;
   logic [3:0]       set_s;
   logic [3:0]       grant_oh_s;

   // Fixed priority: down > rotate > left > right.
   function automatic logic [1:0] pick_code(input logic [3:0] pend);
      if (pend[CODE_DOWN]) begin
         return CODE_DOWN;
      end else if (pend[CODE_ROT]) begin
         return CODE_ROT;
      end else if (pend[CODE_LEFT]) begin
         return CODE_LEFT;
      end else begin
         return CODE_RIGHT;
      end
   endfunction

   // Request queue and gravity counter next-state.
   always_comb begin
      tick_s     = (cnt_q == CNT_MAX);
      grant_s    = (state_q == S_IDLE) && iActive && (|pend_q);
      win_code_s = pick_code(pend_q);
      grant_oh_s = 4'b0000;
      if (grant_s) begin
         grant_oh_s[win_code_s] = 1'b1;
      end else begin
         grant_oh_s = 4'b0000;
      end
      set_s = {iRotate, (iMoveDown | tick_s), iMoveRight, iMoveLeft};
      // A fresh pulse is OR-ed after the grant clear so a re-request wins.
      if (!iActive || (state_q == S_LOCK)) begin
         pend_d = 4'b0000;
      end else begin
         pend_d = (pend_q & ~grant_oh_s) | set_s;
      end
      // A player soft-drop restarts the gravity interval.
      if (!iActive || (state_q == S_LOCK) || iMoveDown) begin
         cnt_d = CNT_ZERO;
      end else if (tick_s) begin
         cnt_d = CNT_ZERO;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Move FSM with registered strobe/lock, plus queue and counter state.
   always_ff @(posedge clk) begin
      if (iReset) begin
         state_q  <= S_IDLE;
         pend_q   <= 4'b0000;
         cnt_q    <= CNT_ZERO;
         code_q   <= CODE_LEFT;
         req_q    <= 1'b0;
         lock_q   <= 1'b0;
`ifdef PIECE_MOVE_LOCK_DELAY_EN
         landed_q <= 1'b0;
`endif
      end else if (iEn) begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         case (state_q)
            S_IDLE: begin
               lock_q <= 1'b0;
               if (grant_s) begin
                  state_q <= S_ISSUE;
                  code_q  <= win_code_s;
                  req_q   <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  req_q   <= 1'b0;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
               req_q   <= 1'b0;
               lock_q  <= 1'b0;
            end
            S_WAIT: begin
               req_q <= 1'b0;
               if (!iMoveDone) begin
                  state_q <= S_WAIT;
                  lock_q  <= 1'b0;
               end else if ((code_q == CODE_DOWN) && iMoveBlocked) begin
`ifdef PIECE_MOVE_LOCK_DELAY_EN
                  if (landed_q) begin
                     state_q <= S_LOCK;
                     lock_q  <= 1'b1;
                  end else begin
                     state_q  <= S_IDLE;
                     lock_q   <= 1'b0;
                     landed_q <= 1'b1;
                  end
`else
                  state_q <= S_LOCK;
                  lock_q  <= 1'b1;
`endif
               end else begin
                  // Blocked lateral/rotate moves are simply dropped.
                  state_q <= S_IDLE;
                  lock_q  <= 1'b0;
`ifdef PIECE_MOVE_LOCK_DELAY_EN
                  if (code_q == CODE_DOWN) begin
                     landed_q <= 1'b0;
                  end else begin
                     landed_q <= landed_q;
                  end
`endif
               end
            end
            S_LOCK: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               lock_q  <= 1'b0;
`ifdef PIECE_MOVE_LOCK_DELAY_EN
               landed_q <= 1'b0;
`endif
            end
            default: begin
               state_q <= S_IDLE;
               req_q   <= 1'b0;
               lock_q  <= 1'b0;
            end
         endcase
      end
   end

   // Strobes are masked while frozen; the FSM holds so they reappear later.
   assign oMoveReq  = req_q & iEn;
   assign oLock     = lock_q & iEn;
   assign oMoveCode = code_q;
   assign oBusy     = (state_q != S_IDLE) | (|pend_q);

endmodule

// File: tb/tb_piece_move_scheduler.sv
module tb_piece_move_scheduler;

   localparam int P = 8;
`ifdef PIECE_MOVE_LOCK_DELAY_EN
   localparam int EXP_LOCKS = 2;
`else
   localparam int EXP_LOCKS = 3;
`endif

   logic       clk = 1'b0;
   logic       iReset = 1'b1, iEn = 1'b1, iActive = 1'b1;
   logic       iMoveLeft = 1'b0, iMoveRight = 1'b0, iRotate = 1'b0, iMoveDown = 1'b0;
   logic       iMoveDone = 1'b0, iMoveBlocked = 1'b0;
   logic       oMoveReq, oLock, oBusy;
   logic [1:0] oMoveCode;

   always #5 clk = ~clk;

   piece_move_scheduler #(.GRAVITY_PERIOD(P), .CNT_W(3)) dut (
      .clk(clk), .iReset(iReset), .iEn(iEn), .iActive(iActive),
      .iMoveLeft(iMoveLeft), .iMoveRight(iMoveRight), .iRotate(iRotate),
      .iMoveDown(iMoveDown), .iMoveDone(iMoveDone), .iMoveBlocked(iMoveBlocked),
      .oMoveReq(oMoveReq), .oMoveCode(oMoveCode), .oLock(oLock), .oBusy(oBusy)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: queued requests by code, gravity age, and what the
   // outside world sees this cycle (strobe shown, move outstanding, lock shown).
   bit [3:0]   m_pend;
   int         m_age;
   bit         m_strobe, m_wait, m_lock;
   logic [1:0] m_code;
`ifdef PIECE_MOVE_LOCK_DELAY_EN
   bit         m_landed;
`endif

   // Engine stand-in.
   bit  eng_busy;
   int  eng_cnt;
   int  eng_dmin = 1, eng_dmax = 1, blk_pct = 0;
   bit  spur_en = 1'b0;

   // Observations for directed checks.
   int         strobes = 0, locks = 0;
   int         last_d = -100, gap_d = 0;
   logic [1:0] seen[$];
   logic [1:0] exp_prio[3] = '{2'b11, 2'b00, 2'b01};

   task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
      end
   endtask

   function automatic bit mdl_busy();
      return m_strobe || m_wait || m_lock || (m_pend != 4'b0000);
   endfunction

   task automatic model_edge();
      int  prio[4];
      int  g;
      bit  nstrobe, nwait, nlock, gravity_due;
      prio = '{2, 3, 0, 1};
      if (iReset) begin
         m_pend = 4'b0000; m_age = 0; m_strobe = 0; m_wait = 0; m_lock = 0;
         m_code = 2'b00; eng_busy = 0;
`ifdef PIECE_MOVE_LOCK_DELAY_EN
         m_landed = 0;
`endif
         return;
      end
      if (!iEn) return;
      gravity_due = (m_age == P - 1);
      nstrobe = 0; nwait = m_wait; nlock = 0; g = -1;
      if (m_strobe) begin
         nwait = 1;
      end else if (m_wait) begin
         if (iMoveDone) begin
            nwait = 0;
            if (m_code == 2'b10) begin
               if (iMoveBlocked) begin
`ifdef PIECE_MOVE_LOCK_DELAY_EN
                  if (m_landed) nlock = 1; else m_landed = 1;
`else
                  nlock = 1;
`endif
               end else begin
`ifdef PIECE_MOVE_LOCK_DELAY_EN
                  m_landed = 0;
`endif
               end
            end
         end
      end else if (m_lock) begin
`ifdef PIECE_MOVE_LOCK_DELAY_EN
         m_landed = 0;
`endif
      end else if (iActive) begin
         for (int k = 0; k < 4; k++) if (g < 0 && m_pend[prio[k]]) g = prio[k];
      end
      if (g >= 0) begin
         nstrobe = 1;
         m_code  = g[1:0];
      end
      if (!iActive || m_lock) begin
         m_pend = 4'b0000;
      end else begin
         if (g >= 0) m_pend[g] = 1'b0;
         if (iMoveLeft) m_pend[0] = 1'b1;
         if (iMoveRight) m_pend[1] = 1'b1;
         if (iMoveDown || gravity_due) m_pend[2] = 1'b1;
         if (iRotate) m_pend[3] = 1'b1;
      end
      m_age    = (!iActive || m_lock || iMoveDown) ? 0 : (m_age + 1) % P;
      m_strobe = nstrobe; m_wait = nwait; m_lock = nlock;
   endtask

   task automatic set_done();
      iMoveDone = 1'b0; iMoveBlocked = 1'b0;
      if (eng_busy && iEn) begin
         if (eng_cnt > 1) begin
            eng_cnt--;
         end else begin
            iMoveDone    = 1'b1;
            iMoveBlocked = ($urandom_range(0, 99) < blk_pct);
            eng_busy     = 1'b0;
         end
      end
      if (spur_en && !iMoveDone) begin
         iMoveBlocked = 1'($urandom_range(0, 1));
         if (!eng_busy && $urandom_range(0, 29) == 0) iMoveDone = 1'b1;
      end
   endtask

   task automatic step(input bit do_chk);
      #1;
      if (do_chk) begin
         check("req",  {1'b0, oMoveReq}, {1'b0, m_strobe & iEn});
         check("code", oMoveCode, m_code);
         check("lock", {1'b0, oLock}, {1'b0, m_lock & iEn});
         check("busy", {1'b0, oBusy}, {1'b0, mdl_busy()});
      end
      if (oMoveReq === 1'b1) begin
         strobes++;
         seen.push_back(oMoveCode);
         if (oMoveCode === 2'b10) begin
            gap_d  = cyc - last_d;
            last_d = cyc;
         end
      end
      if (oLock === 1'b1) locks++;
      if (m_strobe && iEn) begin
         eng_busy = 1'b1;
         eng_cnt  = int'($urandom_range(eng_dmin, eng_dmax));
      end
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick(input bit l, input bit r, input bit rot, input bit d);
      set_done();
      iMoveLeft = l; iMoveRight = r; iRotate = rot; iMoveDown = d;
      step(1'b1);
      iMoveLeft = 1'b0; iMoveRight = 1'b0; iRotate = 1'b0; iMoveDown = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic quiesce();
      iActive = 1'b0;
      idle(6);
      iActive = 1'b1;
   endtask

   initial begin
      int s0;
      // Reset held two cycles with a left pulse that must be ignored.
      iReset = 1'b1; iEn = 1'b1; iActive = 1'b1; iMoveLeft = 1'b1;
      step(1'b0);
      iMoveLeft = 1'b0;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      iReset = 1'b0;
      strobes = 0;
      idle(4);
      check_int("reset_no_strobe", strobes, 0);

      // Single left move, engine answers 3 cycles after the strobe.
      eng_dmin = 3; eng_dmax = 3;
      quiesce();
      s0 = strobes;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle(7);
      check_int("single_strobes", strobes - s0, 1);

      // Simultaneous left/right/rotate -> rotate, left, right.
      eng_dmin = 1; eng_dmax = 1;
      quiesce();
      seen.delete();
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      idle(12);
      for (int k = 0; k < 3; k++) begin
         logic [1:0] got;
         got = (k < seen.size()) ? seen[k] : 2'bxx;
         check("prio_order", got, exp_prio[k]);
      end

      // Gravity spacing, then a soft-drop restarting the interval.
      quiesce();
      idle(30);
      check_int("gravity_gap", gap_d, 8);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      check_int("drop_gap", gap_d, 7);
      idle(10);
      check_int("restart_gap", gap_d, 8);

      // Landing: every down is blocked.
      quiesce();
      blk_pct = 100;
      locks = 0;
      idle(42);
      check_int("lock_count", locks, EXP_LOCKS);
      blk_pct = 0;

      // Freeze during the strobe: exactly one strobe once enable returns.
      quiesce();
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      s0 = strobes;
      iEn = 1'b0;
      idle(3);
      iEn = 1'b1;
      idle(6);
      check_int("freeze_strobes", strobes - s0, 1);

      // Piece goes inactive with a queued down: no strobe.
      quiesce();
      idle(2);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      s0 = strobes;
      iActive = 1'b0;
      idle(10);
      check_int("inactive_strobes", strobes - s0, 0);

      // Randomized traffic against the model.
      iActive = 1'b1; eng_dmin = 1; eng_dmax = 4; blk_pct = 50; spur_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         iReset = ($urandom_range(0, 399) == 0);
         iEn    = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 99) == 0) iActive = ~iActive;
         if (!iActive && $urandom_range(0, 19) == 0) iActive = 1'b1;
         tick($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
